// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store engine driving a grant/response data memory bus.
// Ports: clk, rst_n (async active-low); lsu_valid/lsu_ready request handshake with memWR,
// memCtrl, lsu_addr, lsu_wdata; lsu_done/lsu_err/lsu_rdata completion; lsu_busy pipeline stall;
// dmem_req/we/be/addr/wdata request side and dmem_gnt/rvalid/rdata response side of memory.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic            memWR,
  input  logic [2:0]      memCtrl,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_done,
  output logic            lsu_err,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_busy,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic            we_q;
  logic [2:0]      ctrl_q;
  logic [XLEN-1:0] addr_q, wdata_q, load_data;
  logic [CW-1:0]   cnt;
  logic            in_half, in_word, misalign, q_byte, q_half, sgn, timeout_hit, ok_done;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [3:0]      be_st;
  logic [XLEN-1:0] wrep;
  // Access size is decoded from memCtrl alone; memWR only selects load versus store.
  assign in_half  = memCtrl == 3'b001 || memCtrl == 3'b100 || memCtrl == 3'b110;
  assign in_word  = memCtrl == 3'b010 || memCtrl == 3'b111;
  assign misalign = (in_half && lsu_addr[0]) || (in_word && lsu_addr[1:0] != 2'b00);
  assign q_byte   = ctrl_q == 3'b000 || ctrl_q == 3'b011 || ctrl_q == 3'b101;
  assign q_half   = ctrl_q == 3'b001 || ctrl_q == 3'b100 || ctrl_q == 3'b110;
  assign sgn      = ctrl_q == 3'b000 || ctrl_q == 3'b001;
  assign byte_v   = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_v   = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign load_data = q_byte ? {{(XLEN-8){sgn & byte_v[7]}}, byte_v}
                   : q_half ? {{(XLEN-16){sgn & half_v[15]}}, half_v} : dmem_rdata;
  assign be_st    = q_byte ? 4'b0001 << addr_q[1:0] : q_half ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wrep     = q_byte ? {4{wdata_q[7:0]}} : q_half ? {2{wdata_q[15:0]}} : wdata_q;
  // Counter counts cycles already spent in the current REQ/WAIT visit, so the last
  // permitted cycle is the one where it equals TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  // Only a granted store or a returned load finishes cleanly; any other way into DONE is an error.
  assign ok_done  = (state == REQ && dmem_gnt) || (state == WAIT && dmem_rvalid);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = lsu_valid ? (misalign ? DONE : REQ) : IDLE;
      REQ:  state_nx = dmem_gnt ? (we_q ? DONE : WAIT) : timeout_hit ? DONE : REQ;
      WAIT: state_nx = (dmem_rvalid || timeout_hit) ? DONE : WAIT;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    lsu_ready  = state == IDLE;
    lsu_busy   = state != IDLE;
    lsu_done   = state == DONE;
    dmem_req   = state == REQ;
    dmem_we    = dmem_req && we_q;
    dmem_be    = dmem_req ? (we_q ? be_st : 4'b1111) : 4'b0000;
    dmem_addr  = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dmem_wdata = dmem_we ? wrep : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q      <= 1'b0;
      ctrl_q    <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      lsu_err   <= 1'b0;
      lsu_rdata <= '0;
    end else begin
      if (state == IDLE && lsu_valid) begin
        we_q    <= memWR;
        ctrl_q  <= memCtrl;
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
      end
      cnt <= ((state == REQ || state == WAIT) && state_nx == state) ? cnt + 1'b1 : '0;
      if (state_nx == DONE && state != DONE) begin
        lsu_err   <= !ok_done;
        lsu_rdata <= (state == WAIT && dmem_rvalid) ? load_data : '0;
      end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven and randomized self-checking bench for load_store_unit.
module tb_load_store_unit;
  localparam int TO = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        lsu_valid = 1'b0, memWR = 1'b0, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [2:0]  memCtrl = 3'b000;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0, dmem_rdata = '0;
  logic        lsu_ready, lsu_done, lsu_err, lsu_busy, dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] lsu_rdata, dmem_addr, dmem_wdata;
  int tests = 0, fails = 0;
  typedef struct {
    logic w; logic [2:0] c; logic [31:0] a, wd, rw; int gd, rd;
    logic [3:0] be; logic [31:0] wrep, rdat; logic err;
  } vec_t;
  vec_t tbl[12];
  vec_t v;
  load_store_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .memWR(memWR),
    .memCtrl(memCtrl), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(lsu_done),
    .lsu_err(lsu_err), .lsu_rdata(lsu_rdata), .lsu_busy(lsu_busy), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int sz(input logic [2:0] c);
    return (c == 0 || c == 3 || c == 5) ? 1 : (c == 1 || c == 4 || c == 6) ? 2 : 4;
  endfunction
  function automatic logic mis(input logic [2:0] c, input logic [31:0] a);
    return (int'(a[1:0]) % sz(c)) != 0;
  endfunction
  function automatic logic [3:0] m_be(input logic w, input logic [2:0] c, input logic [31:0] a);
    logic [7:0] m;
    m = ((8'd1 << sz(c)) - 8'd1) << a[1:0];
    return w ? m[3:0] : 4'hF;
  endfunction
  function automatic logic [31:0] m_wd(input logic [2:0] c, input logic [31:0] wd);
    return sz(c) == 1 ? 32'(wd[7:0]) * 32'h01010101 : sz(c) == 2 ? 32'(wd[15:0]) * 32'h00010001 : wd;
  endfunction
  function automatic logic [31:0] m_rd(input logic [2:0] c, input logic [31:0] a, input logic [31:0] rw);
    logic [63:0] m, x;
    m = (64'd1 << (8 * sz(c))) - 64'd1;
    x = ({32'b0, rw} >> (8 * int'(a[1:0]))) & m;
    if (c <= 3'd1 && x[8 * sz(c) - 1]) x = x | ~m;
    return x[31:0];
  endfunction
  task automatic run(input vec_t t);
    logic m, granted, got;
    m = mis(t.c, t.a);
    lsu_valid = 1'b1; memWR = t.w; memCtrl = t.c; lsu_addr = t.a; lsu_wdata = t.wd;
    chk("ready_before", lsu_ready, 1);
    tick;
    lsu_valid = 1'b0;
    if (!m) begin
      granted = 1'b0;
      for (int k = 0; k < TO && !granted; k++) begin
        chk("req", dmem_req, 1);
        chk("we", dmem_we, t.w);
        chk("be", dmem_be, t.be);
        chk("addr", dmem_addr, {t.a[31:2], 2'b00});
        if (t.w) chk("wdata", dmem_wdata, t.wrep);
        chk("busy", lsu_busy, 1);
        chk("done_early", lsu_done, 0);
        lsu_valid = 1'b1; memCtrl = 3'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom; memWR = 1'($urandom);
        dmem_gnt = (k == t.gd); granted = dmem_gnt;
        tick;
        dmem_gnt = 1'b0; lsu_valid = 1'b0;
      end
      if (granted && !t.w) begin
        got = 1'b0;
        for (int k = 0; k < TO && !got; k++) begin
          chk("wait_req", dmem_req, 0);
          chk("done_early", lsu_done, 0);
          dmem_gnt = k[0];
          dmem_rvalid = (k == t.rd);
          dmem_rdata = dmem_rvalid ? t.rw : $urandom;
          got = dmem_rvalid;
          tick;
          dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
        end
      end
    end
    chk("done", lsu_done, 1);
    chk("err", lsu_err, t.err);
    chk("rdata", lsu_rdata, t.rdat);
    chk("done_req", dmem_req, 0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    tick;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("done_pulse", lsu_done, 0);
    chk("ready_after", lsu_ready, 1);
    chk("err_hold", lsu_err, t.err);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 3'd7, 32'h100, 32'hDEADBEEF, 32'h0,        0,  0,  4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 3'd5, 32'h103, 32'h000000A5, 32'h0,        0,  0,  4'h8, 32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 3'd0, 32'h202, 32'h0,        32'h12F03456, 0,  0,  4'hF, 32'h0,        32'hFFFFFFF0, 1'b0};
    tbl[3]  = '{1'b0, 3'd4, 32'h202, 32'h0,        32'h12F03456, 0,  0,  4'hF, 32'h0,        32'h000012F0, 1'b0};
    tbl[4]  = '{1'b0, 3'd2, 32'h200, 32'h0,        32'h12F03456, 1,  1,  4'hF, 32'h0,        32'h12F03456, 1'b0};
    tbl[5]  = '{1'b0, 3'd1, 32'h101, 32'h0,        32'h0,        0,  0,  4'hF, 32'h0,        32'h0,        1'b1};
    tbl[6]  = '{1'b1, 3'd7, 32'h102, 32'h55555555, 32'h0,        0,  0,  4'hF, 32'h0,        32'h0,        1'b1};
    tbl[7]  = '{1'b1, 3'd6, 32'h102, 32'h1234BEEF, 32'h0,        2,  0,  4'hC, 32'hBEEFBEEF, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 3'd3, 32'h201, 32'h0,        32'h12F03456, 0,  2,  4'hF, 32'h0,        32'h00000034, 1'b0};
    tbl[9]  = '{1'b0, 3'd1, 32'h200, 32'h0,        32'h00008001, 0,  0,  4'hF, 32'h0,        32'hFFFF8001, 1'b0};
    tbl[10] = '{1'b1, 3'd7, 32'h300, 32'h11223344, 32'h0,        TO, 0,  4'hF, 32'h11223344, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 3'd2, 32'h204, 32'h0,        32'hCAFEF00D, 0,  TO, 4'hF, 32'h0,        32'h0,        1'b1};
    #2;
    chk("rst_ready", lsu_ready, 1);
    chk("rst_busy", lsu_busy, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_rdata", lsu_rdata, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 12; i++) run(tbl[i]);
    // reset while a load waits for its data
    lsu_valid = 1'b1; memWR = 1'b0; memCtrl = 3'd2; lsu_addr = 32'h400;
    tick;
    lsu_valid = 1'b0;
    chk("rs_req", dmem_req, 1);
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    chk("rs_wait", dmem_req, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_req0", dmem_req, 0);
    chk("rs_done0", lsu_done, 0);
    chk("rs_err0", lsu_err, 0);
    chk("rs_rdata0", lsu_rdata, 0);
    chk("rs_ready", lsu_ready, 1);
    tick;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    tick;
    dmem_rvalid = 1'b0;
    chk("rs_stray", lsu_done, 0);
    tick;
    chk("rs_stray2", lsu_done, 0);
    run('{1'b0, 3'd2, 32'h400, 32'h0, 32'h89ABCDEF, 0, 0, 4'hF, 32'h0, 32'h89ABCDEF, 1'b0});
    for (int i = 0; i < 60; i++) begin
      v.c = 3'($urandom);
      v.w = v.c >= 3'd5;
      v.a = $urandom & 32'h0000FFFF;
      v.wd = $urandom;
      v.rw = $urandom;
      v.gd = ($urandom % 8 == 0) ? TO : int'($urandom % (TO - 1));
      v.rd = ($urandom % 8 == 0) ? TO : int'($urandom % (TO - 1));
      v.be = m_be(v.w, v.c, v.a);
      v.wrep = m_wd(v.c, v.wd);
      v.err = mis(v.c, v.a) || v.gd >= TO || (!v.w && v.rd >= TO);
      v.rdat = (v.err || v.w) ? 32'h0 : m_rd(v.c, v.a, v.rw);
      run(v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
